// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - state_e     : FSM state codes (FETCH..WB); codes 5-7 are unused.
//   - instr_cls_e : instruction classes produced by mc_decode.
//   - opcode/funct constants for the supported instructions.
//   - encodings of the alu_op, npc_sel, reg_dst and wd_sel datapath selects.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    CLS_ADDU,
    CLS_SUBU,
    CLS_JR,
    CLS_ORI,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_JAL,
    CLS_OTHER
  } instr_cls_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  // alu_op encodings
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  // npc_sel encodings
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JUMP = 2'd2;
  localparam logic [1:0] NPC_REG  = 2'd3;

  // reg_dst encodings
  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  // wd_sel encodings
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct -> instruction class mapping.
// Ports:
//   opcode [5:0] in  : IR[31:26]
//   func   [5:0] in  : IR[5:0]
//   cls          out : instruction class; anything unsupported (including
//                      the all-zero nop) maps to CLS_OTHER.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  output instr_cls_e  cls
);

  always_comb begin
    cls = CLS_OTHER;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: cls = CLS_ADDU;
          FN_SUBU: cls = CLS_SUBU;
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_OTHER;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the MIPS datapath.
// Steps each instruction through FETCH / DECODE / EXEC / MEM / WB and drives
// all datapath enables and selects combinationally from the registered state
// and the current opcode/func.
// Ports:
//   clk, reset (sync, active-high)
//   opcode[5:0], func[5:0]  instruction fields from IR
//   zero                    ALU zero flag (used by beq in EXEC)
//   mem_ready               DM access done (only with MC_MEM_WAIT_EN)
//   pc_we, ir_we, reg_we, mem_we          write enables
//   npc_sel[1:0], reg_dst[1:0], alu_src, alu_op[2:0], ext_op, wd_sel[1:0]
//   state[2:0]              current state (debug)
//   instr_done              pulse in the last cycle of each instruction
// Build option: define MC_MEM_WAIT_EN to hold MEM until mem_ready = 1;
// otherwise MEM lasts one cycle and mem_ready is ignored.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic [1:0] npc_sel,
  output logic [1:0] reg_dst,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic       ext_op,
  output logic [1:0] wd_sel,
  output logic [2:0] state,
  output logic       instr_done
);

  state_e     state_q;
  state_e     state_d;
  instr_cls_e cls;
  logic       mem_done;

  // ALU controls selected in EXEC and held through MEM/WB
  logic       alu_src_x;
  logic       ext_op_x;
  logic [2:0] alu_op_x;

  mc_decode u_decode (
    .opcode (opcode),
    .func   (func),
    .cls    (cls)
  );

`ifdef MC_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    alu_src_x = 1'b0;
    ext_op_x  = 1'b0;
    alu_op_x  = ALU_ADD;
    case (cls)
      CLS_SUBU: alu_op_x = ALU_SUB;
      CLS_ORI: begin
        alu_src_x = 1'b1;
        alu_op_x  = ALU_OR;
      end
      CLS_LUI: begin
        alu_src_x = 1'b1;
        alu_op_x  = ALU_LUI;
      end
      CLS_LW, CLS_SW: begin
        alu_src_x = 1'b1;
        ext_op_x  = 1'b1;
      end
      CLS_BEQ: alu_op_x = ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = ST_FETCH;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    npc_sel    = NPC_PC4;
    reg_dst    = RDST_RT;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = 1'b0;
    wd_sel     = WD_ALU;
    instr_done = 1'b0;

    case (state_q)
      ST_FETCH: begin
        pc_we   = 1'b1;
        ir_we   = 1'b1;
        npc_sel = NPC_PC4;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        if (cls == CLS_OTHER) begin
          instr_done = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_src = alu_src_x;
        ext_op  = ext_op_x;
        alu_op  = alu_op_x;
        case (cls)
          CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI: state_d = ST_WB;
          CLS_LW, CLS_SW:                        state_d = ST_MEM;
          CLS_BEQ: begin
            pc_we      = zero;
            npc_sel    = NPC_BR;
            instr_done = 1'b1;
          end
          CLS_J: begin
            pc_we      = 1'b1;
            npc_sel    = NPC_JUMP;
            instr_done = 1'b1;
          end
          CLS_JAL: begin
            pc_we      = 1'b1;
            npc_sel    = NPC_JUMP;
            reg_we     = 1'b1;
            reg_dst    = RDST_RA;
            wd_sel     = WD_PC4;
            instr_done = 1'b1;
          end
          CLS_JR: begin
            pc_we      = 1'b1;
            npc_sel    = NPC_REG;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        alu_src = alu_src_x;
        ext_op  = ext_op_x;
        alu_op  = alu_op_x;
        if (cls == CLS_SW) begin
          // mem_we is held for every MEM cycle while waiting on the DM
          mem_we = 1'b1;
          if (mem_done) begin
            instr_done = 1'b1;
          end else begin
            state_d = ST_MEM;
          end
        end else if (cls == CLS_LW) begin
          state_d = mem_done ? ST_WB : ST_MEM;
        end
      end

      ST_WB: begin
        alu_src    = alu_src_x;
        ext_op     = ext_op_x;
        alu_op     = alu_op_x;
        reg_we     = 1'b1;
        instr_done = 1'b1;
        if (cls == CLS_ADDU || cls == CLS_SUBU) begin
          reg_dst = RDST_RD;
        end
        if (cls == CLS_LW) begin
          wd_sel = WD_DM;
        end
      end

      // Unused codes 5-7: recover to FETCH with everything deasserted
      default: ;
    endcase

    // Reset overrides every output so no write lands on a reset edge
    if (reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      npc_sel    = NPC_PC4;
      reg_dst    = RDST_RT;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      ext_op     = 1'b0;
      wd_sel     = WD_ALU;
      instr_done = 1'b0;
    end
  end

  assign state = reset ? ST_FETCH : state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It takes the opcode and funct fields of the instruction held in the IR, plus the ALU zero flag. It steps each instruction through FETCH / DECODE / EXEC / MEM / WB and drives every datapath write enable and mux select. It replaces the single-cycle combinational controller and sits between the instruction-field splitter and the PC, IR, GRF, ALU, EXT and DM.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high
- opcode  input  6  IR[31:26], stable from the cycle after FETCH
- func  input  6  IR[5:0]
- zero  input  1  ALU result == 0, valid in EXEC
- mem_ready  input  1  DM access complete; used only with MC_MEM_WAIT_EN
- pc_we  output  1  PC write enable
- ir_we  output  1  IR write enable
- reg_we  output  1  GRF write enable
- mem_we  output  1  DM write enable
- npc_sel  output  2  0 = PC+4, 1 = branch target, 2 = j/jal target, 3 = GRF[rs]
- reg_dst  output  2  0 = rt, 1 = rd, 2 = $31
- alu_src  output  1  0 = GRF[rt], 1 = EXT output
- alu_op  output  3  0 = add, 1 = sub, 2 = or, 3 = lui (imm << 16)
- ext_op  output  1  0 = zero-extend, 1 = sign-extend
- wd_sel  output  2  0 = ALU, 1 = DM, 2 = PC+4
- state  output  3  current state, for debug
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction

## Operation
- Supported instructions: addu, subu, jr (R-type, opcode 0), ori, lui, lw, sw, beq, j, jal.
- Any other opcode/funct pair, including the all-zero nop, is class OTHER.
- FETCH: ir_we = 1, pc_we = 1, npc_sel = 0. Next state is DECODE.
- DECODE: all enables 0.
  - OTHER: instr_done = 1, next state FETCH.
  - All other classes: next state EXEC.
- EXEC:
  - addu/subu: alu_src = 0; alu_op = 0 (addu) or 1 (subu). Next state WB.
  - ori/lui: alu_src = 1, ext_op = 0; alu_op = 2 (ori) or 3 (lui). Next state WB.
  - lw/sw: alu_src = 1, ext_op = 1, alu_op = 0. Next state MEM.
  - beq: alu_src = 0, alu_op = 1, pc_we = zero, npc_sel = 1, instr_done = 1. Next state FETCH.
  - j: pc_we = 1, npc_sel = 2, instr_done = 1. Next state FETCH.
  - jal: pc_we = 1, npc_sel = 2, reg_we = 1, reg_dst = 2, wd_sel = 2, instr_done = 1. Next state FETCH.
  - jr: pc_we = 1, npc_sel = 3, instr_done = 1. Next state FETCH.
- MEM:
  - sw: mem_we = 1, instr_done = 1. Next state FETCH.
  - lw: next state WB.
  - alu_src, ext_op and alu_op keep their EXEC values.
- WB: reg_we = 1, instr_done = 1. Next state FETCH.
  - R-type: reg_dst = 1, wd_sel = 0.
  - ori/lui: reg_dst = 0, wd_sel = 0.
  - lw: reg_dst = 0, wd_sel = 1.
  - The ALU controls keep their EXEC values.
- Any output not listed for a state is 0.
- Outputs are combinational from the registered state and the opcode/func inputs. No output is registered.

## Timing
- While reset = 1, all outputs except state are forced to 0. state shows FETCH (0). On the clock edge with reset = 1, the state register loads FETCH.
- On the clock edge with reset = 1, no write takes effect, because every enable is forced to 0.
- When reset is asserted mid-instruction, the instruction is abandoned on the next edge and no further enables assert. On the first cycle after deassertion, FETCH issues pc_we and ir_we.
- Latencies in cycles:
  - OTHER: 2
  - beq, j, jal, jr: 3
  - addu, subu, ori, lui, sw: 4
  - lw: 5
- instr_done asserts exactly once per instruction, in the same cycle as its final write enable. The following cycle is always FETCH.
- beq with zero = 0 still takes 3 cycles; pc_we = 0 in EXEC.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Codes 5–7 are unreachable; if entered, the next state is FETCH and all enables are 0.

## Configuration
- MC_MEM_WAIT_EN defined:
  - MEM is held until mem_ready = 1; mem_ready is sampled every cycle in MEM.
  - For sw, mem_we stays high for every MEM cycle. instr_done asserts only in the MEM cycle where mem_ready = 1.
  - lw moves to WB in the cycle after mem_ready = 1.
- MC_MEM_WAIT_EN undefined: mem_ready is ignored and MEM lasts exactly 1 cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - state codes, instruction-class enum, opcode/funct constants;
  - the alu_op, npc_sel, reg_dst and wd_sel encodings.
- Sub-module mc_decode: combinational mapping from opcode/func to instruction class.
- mc_ctrl contains the state register, next-state logic and the per-state output decode.

## Test plan
- Reset held 3 cycles, then released, with IR = 0x00000000: during reset every enable is 0 and state = 0. After release: FETCH (pc_we = 1, ir_we = 1), then DECODE with instr_done = 1, then FETCH.
- addu (opcode 0x00, func 0x21) → states 0,1,2,4. In WB: reg_we = 1, reg_dst = 1, wd_sel = 0, instr_done = 1.
- lw (0x23) → states 0,1,2,3,4. In EXEC: alu_src = 1, ext_op = 1. In WB: wd_sel = 1, reg_dst = 0, reg_we = 1.
- beq (0x04): zero = 1 → pc_we = 1, npc_sel = 1 in EXEC. zero = 0 → pc_we = 0. In both cases the next state is FETCH.
- jal (0x03) → in EXEC: reg_dst = 2, wd_sel = 2, npc_sel = 2, pc_we = 1, reg_we = 1.
- With MC_MEM_WAIT_EN, sw (0x2B) and mem_ready low for 2 cycles → MEM lasts 3 cycles with mem_we high throughout. instr_done asserts only in the third cycle. Reset asserted in the second cycle → enables drop to 0 and the state is FETCH after the next edge.
